param_smpl_queue: RTL and testbench

//   Parametrised multi-channel circular sample queue feeding the FIR filter banks.

---
 rtl/param_smpl_queue.sv | 169 ++++++++++++++++
 tb/tb_param_smpl_queue.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_smpl_queue.sv
// param_smpl_queue: multi-channel circular sample queue for the FIR filter banks.
// Each accepted sample is written into a per-channel circular RAM. After every
// write, the newest READ_LEN samples are replayed oldest first, one per clock.
// A sample arriving mid-readout queues one back-to-back readout. A second such
// sample sets the sticky overrun flag.
// Optional build macro PARAM_SMPL_QUEUE_DECIMATE_EN: accept only alternate strobes.

// One channel of storage: simple dual-port RAM with a registered read port.
module smpl_ram #(
    parameter int DATA_W = 16,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**AW];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read register updates only while reading, so it stays 0 from reset to the first readout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

module param_smpl_queue #(
    parameter int DATA_W   = 16,
    parameter int NUM_CH   = 2,
    parameter int DEPTH    = 1024,
    parameter int READ_LEN = 1021
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wrt_smpl,
    input  logic [NUM_CH*DATA_W-1:0] smpl_in,
    input  logic                     clr_ovr,
    output logic [NUM_CH*DATA_W-1:0] smpl_out,
    output logic                     sequencing,
    output logic                     smpl_vld,
    output logic                     full,
    output logic                     overrun
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {FILL, IDLE, READ} state_t;

    state_t        state;
    logic          acc;
    logic          pending;
    logic [AW-1:0] new_ptr, old_ptr, rd_ptr, rd_cnt, fill_cnt;
    logic [AW-1:0] new_ptr_nxt, win_start;
    logic          last_beat;

`ifdef PARAM_SMPL_QUEUE_DECIMATE_EN
    logic dec_tgl;

    // Half-rate decimation: the first strobe after reset is taken, then every other one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           dec_tgl <= 1'b0;
        else if (wrt_smpl) dec_tgl <= ~dec_tgl;
    end

    assign acc = wrt_smpl & ~dec_tgl;
`else
    assign acc = wrt_smpl;
`endif

    // Window that ends on the newest sample, counting a write landing this cycle.
    assign new_ptr_nxt = new_ptr + AW'(acc);
    assign win_start   = new_ptr_nxt - AW'(READ_LEN);
    assign last_beat   = (rd_cnt == AW'(READ_LEN - 1));

    // Control FSM: fill tracking, readout sequencing, pending/overrun bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            new_ptr    <= '0;
            old_ptr    <= '0;
            rd_ptr     <= '0;
            rd_cnt     <= '0;
            fill_cnt   <= '0;
            pending    <= 1'b0;
            full       <= 1'b0;
            overrun    <= 1'b0;
            sequencing <= 1'b0;
        end else begin
            new_ptr <= new_ptr_nxt;
            // A set event later in this block overrides the clear.
            if (clr_ovr) overrun <= 1'b0;
            case (state)
                FILL: begin
                    if (acc) begin
                        fill_cnt <= fill_cnt + AW'(1);
                        if (fill_cnt == AW'(READ_LEN - 1)) begin
                            full       <= 1'b1;
                            old_ptr    <= win_start;
                            rd_ptr     <= win_start;
                            rd_cnt     <= '0;
                            sequencing <= 1'b1;
                            state      <= READ;
                        end
                    end
                end
                IDLE: begin
                    if (acc) begin
                        old_ptr    <= old_ptr + AW'(1);
                        rd_ptr     <= old_ptr + AW'(1);
                        rd_cnt     <= '0;
                        sequencing <= 1'b1;
                        state      <= READ;
                    end
                end
                READ: begin
                    rd_ptr <= rd_ptr + AW'(1);
                    rd_cnt <= rd_cnt + AW'(1);
                    if (acc && pending) overrun <= 1'b1;
                    if (last_beat) begin
                        if (pending || acc) begin
                            // Restart on the newest window. With a single pending write
                            // this equals old_ptr+1; after an overrun it skips ahead.
                            pending <= 1'b0;
                            old_ptr <= win_start;
                            rd_ptr  <= win_start;
                            rd_cnt  <= '0;
                        end else begin
                            sequencing <= 1'b0;
                            state      <= IDLE;
                        end
                    end else if (acc) begin
                        pending <= 1'b1;
                    end
                end
                default: begin
                    sequencing <= 1'b0;
                    state      <= FILL;
                end
            endcase
        end
    end

    // Read data appears one cycle after its address, so valid trails sequencing by one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) smpl_vld <= 1'b0;
        else     smpl_vld <= sequencing;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        smpl_ram #(.DATA_W(DATA_W), .AW(AW)) u_ram (
            .clk   (clk),
            .rst   (rst),
            .we    (acc),
            .waddr (new_ptr),
            .wdata (smpl_in[c*DATA_W +: DATA_W]),
            .re    (sequencing),
            .raddr (rd_ptr),
            .rdata (smpl_out[c*DATA_W +: DATA_W])
        );
    end
endmodule

// File: tb/tb_param_smpl_queue.sv
// Bench for param_smpl_queue: a default-size instance (a) and a small
// 4-channel DEPTH=16 instance (b). Readout windows are predicted from a
// history of every accepted sample.
module tb_param_smpl_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        wrt_a, wrt_b, clr_a, clr_b;
    logic [63:0] smpl_in;
    logic [31:0] out_a;
    logic [63:0] out_b;
    logic        seq_a, vld_a, full_a, ovr_a;
    logic        seq_b, vld_b, full_b, ovr_b;

    always #5 clk = ~clk;

    param_smpl_queue #(.DATA_W(16), .NUM_CH(2), .DEPTH(1024), .READ_LEN(1021)) dut_a (
        .clk(clk), .rst(rst), .wrt_smpl(wrt_a), .smpl_in(smpl_in[31:0]), .clr_ovr(clr_a),
        .smpl_out(out_a), .sequencing(seq_a), .smpl_vld(vld_a), .full(full_a), .overrun(ovr_a));

    param_smpl_queue #(.DATA_W(16), .NUM_CH(4), .DEPTH(16), .READ_LEN(13)) dut_b (
        .clk(clk), .rst(rst), .wrt_smpl(wrt_b), .smpl_in(smpl_in), .clr_ovr(clr_b),
        .smpl_out(out_b), .sequencing(seq_b), .smpl_vld(vld_b), .full(full_b), .overrun(ovr_b));

    typedef struct {
        bit trig;      // issue a triggering write from IDLE first
        int inj_a;     // beat of first mid-readout write (-1 none)
        int inj_b;     // beat of second mid-readout write (-1 none)
        int clr_at;    // beat carrying clr_ovr (-1 none)
        bit exp_ovr;   // overrun after the readout
    } vec_t;

    bit          sel;          // 0: dut_a, 1: dut_b
    int          rl, nch;
    logic [15:0] hist[$];
    logic [15:0] next_val;
    int          auto_wr;
    int          n_cmp, n_bad;
    int          nl, last, bad, iter;
    bit          more;
    vec_t        tbl[13];

    function automatic logic [15:0] chan(input logic [15:0] v, input int c);
        return v ^ (16'(c) << 12);
    endfunction

    function automatic logic m_seq();  return sel ? seq_b  : seq_a;  endfunction
    function automatic logic m_vld();  return sel ? vld_b  : vld_a;  endfunction
    function automatic logic m_full(); return sel ? full_b : full_a; endfunction
    function automatic logic m_ovr();  return sel ? ovr_b  : ovr_a;  endfunction
    function automatic logic [15:0] m_out(input int c);
        logic [63:0] t;
        t = sel ? out_b : {32'h0, out_a};
        return t[c*16 +: 16];
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic idle_in();
        wrt_a = 1'b0; wrt_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    endtask

    task automatic drive(input bit wr, input logic [15:0] v, input bit clr);
        for (int c = 0; c < 4; c++) smpl_in[c*16 +: 16] = chan(v, c);
        if (sel) begin wrt_b = wr; clr_b = clr; end
        else     begin wrt_a = wr; clr_a = clr; end
    endtask

    // Strobe one sample; rec=1 records it as accepted.
    task automatic write_smpl(input logic [15:0] v, input bit rec);
        drive(1'b1, v, 1'b0);
        if (rec) hist.push_back(v);
        @(negedge clk);
        idle_in();
    endtask

    // Called at the negedge of beat 0. Checks one readout of window ending at
    // hist[lst], optionally writing during it. Returns at the negedge after the
    // last beat, which is beat 0 of the next readout when nmore is set.
    task automatic run_readout(input string nm, input int lst,
                               input int inj_a, input logic [15:0] val_a,
                               input int inj_b, input logic [15:0] val_b,
                               input int clr_at, output int nlst, output bit nmore);
        int bseq, bvld, bdat, fbeat, idx;
        logic [15:0] fgot, fexp, v;
        bit wr;
        bseq = 0; bvld = 0; bdat = 0; fbeat = -1; fgot = '0; fexp = '0;
        nlst = lst; nmore = 1'b0;
        for (int i = 0; i <= rl; i++) begin
            if (i < rl) begin
                if (m_seq() !== 1'b1) bseq++;
            end else begin
                if (m_seq() !== nmore) bseq++;
            end
            if (i >= 1) begin
                if (m_vld() !== 1'b1) bvld++;
                idx = lst - rl + i;
                for (int c = 0; c < nch; c++) begin
                    if (idx < 0 || m_out(c) !== chan(hist[idx], c)) begin
                        if (bdat == 0) begin
                            fbeat = i - 1; fgot = m_out(c);
                            fexp = (idx < 0) ? 16'h0 : chan(hist[idx], c);
                        end
                        bdat++;
                    end
                end
            end
            idle_in();
            if (i < rl) begin
                wr = 1'b1; v = '0;
                if (i == inj_a)      v = val_a;
                else if (i == inj_b) v = val_b;
                else if (auto_wr > 0) begin v = next_val; next_val++; auto_wr--; end
                else wr = 1'b0;
                drive(wr, v, (i == clr_at));
                if (wr) begin
                    hist.push_back(v);
                    nlst = hist.size() - 1;
                    nmore = 1'b1;
                end
                @(negedge clk);
            end
        end
        chk({nm, ".seq_bad_beats"}, 64'(bseq), 64'd0);
        chk({nm, ".vld_bad_beats"}, 64'(bvld), 64'd0);
        n_cmp++;
        if (bdat != 0) begin
            n_bad++;
            $display("FAIL %s.data: %0d bad, first at beat %0d got %h expected %h",
                     nm, bdat, fbeat, fgot, fexp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_cmp = 0; n_bad = 0; auto_wr = 0; next_val = 16'h0;
        sel = 1'b0; rl = 1021; nch = 2;
        smpl_in = '0;
        idle_in();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst.seq_a", seq_a, 0);
        chk("rst.vld_a", vld_a, 0);
        chk("rst.full_a", full_a, 0);
        chk("rst.ovr_a", ovr_a, 0);
        chk("rst.out_a", out_a, 0);
        chk("rst.out_b", out_b, 0);
        chk("rst.seq_b", seq_b, 0);

`ifdef PARAM_SMPL_QUEUE_DECIMATE_EN
        // Alternate strobes only: 25 strobes deliver 13 samples, the odd ones.
        sel = 1'b1; rl = 13; nch = 4;
        bad = 0;
        for (int k = 1; k <= 25; k++) begin
            if (seq_b !== 1'b0) bad++;
            write_smpl(16'(k), (k % 2) == 1);
        end
        chk("dec.quiet", 64'(bad), 0);
        chk("dec.full", full_b, 1);
        run_readout("dec", 12, -1, 0, -1, 0, -1, nl, more);
`else
        // 1: fill, first readout on the 1021st sample
        bad = 0;
        for (int k = 1; k <= 1020; k++) begin
            write_smpl(16'(k), 1'b1);
            if (seq_a !== 1'b0 || full_a !== 1'b0) bad++;
        end
        chk("t1.fill_quiet", 64'(bad), 0);
        write_smpl(16'd1021, 1'b1);
        chk("t1.full", full_a, 1);
        run_readout("t1", 1020, -1, 0, -1, 0, -1, nl, more);

        // 2: write from IDLE, window slides by one; valid trails sequencing
        write_smpl(16'd1022, 1'b1);
        chk("t2.vld_lag_start", vld_a, 0);
        run_readout("t2", hist.size() - 1, -1, 0, -1, 0, -1, nl, more);
        @(negedge clk);
        chk("t2.vld_lag_end", vld_a, 0);

        // 3: one write mid-readout -> chained readout ending on it
        write_smpl(16'd1023, 1'b1);
        run_readout("t3a", hist.size() - 1, 500, 16'hAAAA, -1, 0, -1, nl, more);
        run_readout("t3b", nl, -1, 0, -1, 0, -1, nl, more);
        chk("t3.ovr", ovr_a, 0);

        // 4: two writes mid-readout -> overrun, newest window, then clear
        write_smpl(16'h0400, 1'b1);
        run_readout("t4a", hist.size() - 1, 100, 16'h1111, 700, 16'h2222, -1, nl, more);
        chk("t4.ovr_set", ovr_a, 1);
        run_readout("t4b", nl, -1, 0, -1, 0, -1, nl, more);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        chk("t4.ovr_clr", ovr_a, 0);

        // 5: 3000-sample burst across pointer wraps
        next_val = 16'h5000;
        write_smpl(next_val, 1'b1);
        next_val++;
        auto_wr = 2999;
        last = hist.size() - 1;
        more = 1'b1;
        iter = 0;
        while (more && iter < 10) begin
            run_readout($sformatf("t5.%0d", iter), last, -1, 0, -1, 0, -1, nl, more);
            last = nl;
            iter++;
        end
        chk("t5.ovr", ovr_a, 1);

        // Small instance: table-driven readout scenarios
        sel = 1'b1; rl = 13; nch = 4;
        hist.delete();
        bad = 0;
        for (int k = 1; k <= 12; k++) begin
            write_smpl(16'h0100 + 16'(k), 1'b1);
            if (seq_b !== 1'b0 || full_b !== 1'b0) bad++;
        end
        chk("b.fill_quiet", 64'(bad), 0);
        write_smpl(16'h010D, 1'b1);
        chk("b.full", full_b, 1);

        tbl[0]  = '{0, -1, -1, -1, 0};
        tbl[1]  = '{1, -1, -1, -1, 0};
        tbl[2]  = '{1,  5, -1, -1, 0};
        tbl[3]  = '{0, -1, -1, -1, 0};
        tbl[4]  = '{1, 12, -1, -1, 0};
        tbl[5]  = '{0,  0, -1, -1, 0};
        tbl[6]  = '{0,  3, 12, -1, 1};
        tbl[7]  = '{0, -1, -1,  4, 0};
        tbl[8]  = '{1,  2,  9,  9, 1};
        tbl[9]  = '{0, -1, -1, -1, 1};
        tbl[10] = '{1, -1, -1,  0, 0};
        tbl[11] = '{1,  6,  7, -1, 1};
        tbl[12] = '{0, -1, -1, -1, 1};
        nl = 12;
        next_val = 16'h0200;
        for (int e = 0; e < 13; e++) begin
            if (tbl[e].trig) begin
                write_smpl(next_val, 1'b1);
                next_val++;
                nl = hist.size() - 1;
            end
            run_readout($sformatf("tbl%0d", e), nl, tbl[e].inj_a, next_val,
                        tbl[e].inj_b, next_val + 16'd1, tbl[e].clr_at, nl, more);
            next_val = next_val + 16'd2;
            chk($sformatf("tbl%0d.ovr", e), ovr_b, 64'(tbl[e].exp_ovr));
        end

        // 6: asynchronous reset mid-readout, then back in FILL
        write_smpl(next_val, 1'b1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6.seq", seq_b, 0);
        chk("t6.vld", vld_b, 0);
        chk("t6.full", full_b, 0);
        chk("t6.ovr", ovr_b, 0);
        chk("t6.out_b", out_b, 0);
        chk("t6.full_a", full_a, 0);
        chk("t6.out_a", out_a, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        hist.delete();
        bad = 0;
        for (int k = 1; k <= 12; k++) begin
            write_smpl(16'h0700 + 16'(k), 1'b1);
            if (seq_b !== 1'b0 || full_b !== 1'b0) bad++;
        end
        chk("t6.refill_quiet", 64'(bad), 0);
        write_smpl(16'h070D, 1'b1);
        chk("t6.refull", full_b, 1);
        run_readout("t6.refill", 12, -1, 0, -1, 0, -1, nl, more);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
